// File: rtl/orv64_pmp_seq_chk_pkg.sv
// Shared types and parameters for the sequential PMP checker.
package orv64_pmp_seq_chk_pkg;

    localparam int ORV64_PHY_ADDR_WIDTH = 56;
    localparam int ORV64_PMPADDR_WIDTH  = ORV64_PHY_ADDR_WIDTH - 2;
    localparam int ORV64_PMP_N_ENTRIES  = 16;
    localparam logic [1:0] ORV64_PRV_M  = 2'd3;

    // Encoding matches the pmpcfg.A field.
    typedef enum logic [1:0] {
        PMP_OFF   = 2'd0,
        PMP_TOR   = 2'd1,
        PMP_NA4   = 2'd2,
        PMP_NAPOT = 2'd3
    } orv64_pmp_mode_e;

    typedef enum logic [1:0] {
        PMP_ACC_READ  = 2'd0,
        PMP_ACC_WRITE = 2'd1,
        PMP_ACC_EXEC  = 2'd2
    } orv64_pmp_acc_t;

    typedef enum logic [1:0] {
        CHK_IDLE = 2'd0,
        CHK_SCAN = 2'd1,
        CHK_RESP = 2'd2
    } orv64_pmp_chk_state_e;

    typedef struct packed {
        logic            l;
        logic [1:0]      rsvd;
        orv64_pmp_mode_e a;
        logic            x;
        logic            w;
        logic            r;
    } orv64_csr_pmpcfg_t;

    typedef logic [ORV64_PMPADDR_WIDTH-1:0] orv64_csr_pmpaddr_t;

    // Permission bit of an entry for the requested access type.
    function automatic logic pmp_acc_perm(input orv64_csr_pmpcfg_t cfg, input orv64_pmp_acc_t acc);
        case (acc)
            PMP_ACC_READ:  return cfg.r;
            PMP_ACC_WRITE: return cfg.w;
            PMP_ACC_EXEC:  return cfg.x;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/orv64_pmp_seq_chk_napot_addr.sv
// NAPOT range decoder: turns one pmpaddr value into an inclusive byte range.
import orv64_pmp_seq_chk_pkg::*;

module orv64_napot_addr (
    input  orv64_csr_pmpaddr_t               pmpaddr,
    output logic [ORV64_PHY_ADDR_WIDTH-1:0]  napot_base,
    output logic [ORV64_PHY_ADDR_WIDTH-1:0]  napot_bounds
);

    orv64_csr_pmpaddr_t mask;

    // Trailing ones plus the first zero above them select the region's word offset bits.
    always_comb begin
        mask         = pmpaddr ^ (pmpaddr + ORV64_PMPADDR_WIDTH'(1));
        napot_base   = {pmpaddr & ~mask, 2'b00};
        napot_bounds = {pmpaddr | mask, 2'b11};
    end

endmodule

// File: rtl/orv64_pmp_seq_chk.sv
// Sequential PMP checker: scans one entry per cycle against a latched request.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready
// are both high. req_ready is high only in IDLE. Once resp_valid rises, all
// resp_* stay stable until the edge where resp_ready is also high.
import orv64_pmp_seq_chk_pkg::*;

module orv64_pmp_seq_chk #(
    parameter int N_ENTRIES = ORV64_PMP_N_ENTRIES
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  orv64_csr_pmpcfg_t  [N_ENTRIES-1:0]    pmpcfg,
    input  orv64_csr_pmpaddr_t [N_ENTRIES-1:0]    pmpaddr,
    input  logic                                  pmp_cfg_upd,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [ORV64_PHY_ADDR_WIDTH-1:0]       req_paddr,
    input  logic [1:0]                            req_size,
    input  orv64_pmp_acc_t                        req_acc,
    input  logic [1:0]                            req_prv,
    output logic                                  resp_valid,
    input  logic                                  resp_ready,
    output logic                                  resp_allow,
    output logic                                  resp_hit,
    output logic [5:0]                            resp_idx,
    output orv64_pmp_chk_state_e                  dbg_state
);

    localparam int PA = ORV64_PHY_ADDR_WIDTH;

    orv64_pmp_chk_state_e state;
    logic [5:0]           ptr;
    logic [PA-1:0]        lat_paddr;
    logic [1:0]           lat_size;
    orv64_pmp_acc_t       lat_acc;
    logic [1:0]           lat_prv;

    orv64_csr_pmpcfg_t    cur_cfg;
    orv64_csr_pmpaddr_t   cur_addr;
    orv64_csr_pmpaddr_t   prev_addr;
    logic [PA-1:0]        napot_base;
    logic [PA-1:0]        napot_bounds;
    logic [PA-1:0]        end_addr;
    logic [PA-1:0]        rng_lo;
    logic [PA-1:0]        rng_hi;
    logic [PA-1:0]        tor_upper;
    logic                 rng_en;
    logic                 start_in;
    logic                 end_in;
    logic                 ent_hit;
    logic                 ent_allow;
    logic                 last_ent;

    assign dbg_state = state;

    // Select the entry under the pointer and its predecessor's address (TOR lower bound).
    always_comb begin
        cur_cfg   = '0;
        cur_addr  = '0;
        prev_addr = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (ptr == 6'(i)) begin
                cur_cfg  = pmpcfg[i];
                cur_addr = pmpaddr[i];
            end
            if (ptr == 6'(i + 1)) begin
                prev_addr = pmpaddr[i];
            end
        end
    end

    orv64_napot_addr u_napot_addr (
        .pmpaddr      (cur_addr),
        .napot_base   (napot_base),
        .napot_bounds (napot_bounds)
    );

    // Build the current entry's inclusive range and classify the access against it.
    always_comb begin
        end_addr  = lat_paddr | PA'((4'd1 << lat_size) - 4'd1);
        tor_upper = {cur_addr, 2'b00};
        rng_lo    = '0;
        rng_hi    = '0;
        rng_en    = 1'b0;
        case (cur_cfg.a)
            PMP_NA4: begin
                rng_lo = {cur_addr, 2'b00};
                rng_hi = {cur_addr, 2'b11};
                rng_en = 1'b1;
            end
            PMP_NAPOT: begin
                rng_lo = napot_base;
                rng_hi = napot_bounds;
                rng_en = 1'b1;
            end
            PMP_TOR: begin
                rng_lo = (ptr == 6'd0) ? '0 : {prev_addr, 2'b00};
                rng_hi = tor_upper - PA'(1);
                rng_en = (tor_upper > rng_lo);
            end
            default: begin
                rng_en = 1'b0;
            end
        endcase
        start_in = rng_en && (rng_lo <= lat_paddr) && (lat_paddr <= rng_hi);
        end_in   = rng_en && (rng_lo <= end_addr) && (end_addr <= rng_hi);
        // Any overlap is a hit; a straddling access is a fault.
        ent_hit  = start_in || end_in;
        if ((lat_prv == ORV64_PRV_M) && !cur_cfg.l) begin
            ent_allow = 1'b1;
        end else begin
            ent_allow = pmp_acc_perm(cur_cfg, lat_acc) && !(start_in ^ end_in);
        end
        last_ent = (ptr == 6'(N_ENTRIES - 1));
    end

    // Control FSM with registered request/response outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= CHK_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_allow <= 1'b0;
            resp_hit   <= 1'b0;
            resp_idx   <= '0;
            ptr        <= '0;
            lat_paddr  <= '0;
            lat_size   <= '0;
            lat_acc    <= PMP_ACC_READ;
            lat_prv    <= '0;
        end else begin
            case (state)
                CHK_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_paddr <= req_paddr;
                        lat_size  <= req_size;
                        lat_acc   <= req_acc;
                        lat_prv   <= req_prv;
                        ptr       <= '0;
                        req_ready <= 1'b0;
                        state     <= CHK_SCAN;
                    end
                end
                CHK_SCAN: begin
                    if (pmp_cfg_upd) begin
                        // CSR contents changed under us: rescan from the top.
                        ptr <= '0;
                    end else if (ent_hit) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                        resp_idx   <= ptr;
                        resp_allow <= ent_allow;
                        state      <= CHK_RESP;
                    end else if (last_ent) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_idx   <= '0;
                        resp_allow <= (lat_prv == ORV64_PRV_M);
                        state      <= CHK_RESP;
                    end else begin
                        ptr <= ptr + 6'd1;
                    end
                end
                CHK_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= CHK_IDLE;
                    end
                end
                default: begin
                    state     <= CHK_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_orv64_pmp_seq_chk.sv
// Directed bench for the sequential PMP checker with a queue-based scoreboard.
import orv64_pmp_seq_chk_pkg::*;

module tb_orv64_pmp_seq_chk;

    localparam int N  = 16;
    localparam int PA = ORV64_PHY_ADDR_WIDTH;
    localparam int W  = 24;   // {resp cycle[15:0], hit, idx[5:0], allow}

    logic                         clk;
    logic                         rstn;
    orv64_csr_pmpcfg_t  [N-1:0]   pmpcfg;
    orv64_csr_pmpaddr_t [N-1:0]   pmpaddr;
    logic                         pmp_cfg_upd;
    logic                         req_valid;
    logic                         req_ready;
    logic [PA-1:0]                req_paddr;
    logic [1:0]                   req_size;
    orv64_pmp_acc_t               req_acc;
    logic [1:0]                   req_prv;
    logic                         resp_valid;
    logic                         resp_ready;
    logic                         resp_allow;
    logic                         resp_hit;
    logic [5:0]                   resp_idx;
    orv64_pmp_chk_state_e         dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_fail;
    int           cyc;

    orv64_pmp_seq_chk #(.N_ENTRIES(N)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pmpcfg      (pmpcfg),
        .pmpaddr     (pmpaddr),
        .pmp_cfg_upd (pmp_cfg_upd),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_paddr   (req_paddr),
        .req_size    (req_size),
        .req_acc     (req_acc),
        .req_prv     (req_prv),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_allow  (resp_allow),
        .resp_hit    (resp_hit),
        .resp_idx    (resp_idx),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic orv64_csr_pmpcfg_t mk_cfg(input logic l, input orv64_pmp_mode_e a,
                                                 input logic x, input logic w, input logic r);
        orv64_csr_pmpcfg_t c;
        c.l = l; c.rsvd = 2'b00; c.a = a; c.x = x; c.w = w; c.r = r;
        return c;
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) begin
            pmpcfg[i]  = '0;
            pmpaddr[i] = '0;
        end
    endtask

    // ---------------- driver ----------------
    // Presents one request, waits for acceptance, and pushes the expected response.
    task automatic send(input logic [PA-1:0] pa, input logic [1:0] sz, input orv64_pmp_acc_t acc,
                        input logic [1:0] prv, input logic h, input logic [5:0] idx,
                        input logic al, input int lat, input bit push);
        int guard;
        guard = 0;
        @(negedge clk);
        req_paddr = pa;
        req_size  = sz;
        req_acc   = acc;
        req_prv   = prv;
        req_valid = 1'b1;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_accept_timeout: req_ready stayed 0 expected 1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) exp_q.push_back({16'(cyc + lat - 1), h, idx, al});
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout: %0d responses outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit           in_resp;
    int           first_cyc;
    logic [7:0]   snap;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rstn) begin
            in_resp = 1'b0;
        end else if (resp_valid) begin
            if (!in_resp) begin
                in_resp   = 1'b1;
                first_cyc = cyc;
                snap      = {resp_hit, resp_idx, resp_allow};
            end else begin
                check("resp_stable", {56'd0, resp_hit, resp_idx, resp_allow}, {56'd0, snap});
                check("req_ready_in_resp", 64'(req_ready), 64'd0);
            end
            if (resp_ready) begin
                in_resp = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got hit=%0d idx=%0d allow=%0d expected none",
                             resp_hit, resp_idx, resp_allow);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_hit", 64'(resp_hit), 64'(e[7]));
                    check("resp_idx", 64'(resp_idx), 64'(e[6:1]));
                    check("resp_allow", 64'(resp_allow), 64'(e[0]));
                    check("resp_cycle", 64'(16'(first_cyc)), 64'(e[23:8]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        rstn        = 1'b0;
        pmp_cfg_upd = 1'b0;
        req_valid   = 1'b0;
        req_paddr   = '0;
        req_size    = '0;
        req_acc     = PMP_ACC_READ;
        req_prv     = 2'd0;
        resp_ready  = 1'b1;
        clear_cfg();

        #12;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_hit", 64'(resp_hit), 64'd0);
        check("rst_resp_idx", 64'(resp_idx), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(CHK_IDLE));
        @(negedge clk);
        rstn = 1'b1;

        // NAPOT entry 3, R only, covering 0x8000_0000 upward
        clear_cfg();
        pmpcfg[3]  = mk_cfg(1'b0, PMP_NAPOT, 1'b0, 1'b0, 1'b1);
        pmpaddr[3] = 54'h2000_01FF;
        send(56'h8000_0100, 2'd3, PMP_ACC_READ,  2'd0, 1'b1, 6'd3, 1'b1, 5, 1'b1);
        wait_done();
        send(56'h8000_0100, 2'd3, PMP_ACC_WRITE, 2'd0, 1'b1, 6'd3, 1'b0, 5, 1'b1);
        wait_done();

        // TOR entry 0 covering 0x0..0xFFF, RWX
        clear_cfg();
        pmpcfg[0]  = mk_cfg(1'b0, PMP_TOR, 1'b1, 1'b1, 1'b1);
        pmpaddr[0] = 54'h400;
        send(56'hFFC,  2'd3, PMP_ACC_EXEC, 2'd0, 1'b1, 6'd0, 1'b1, 2, 1'b1);
        wait_done();
        send(56'h1000, 2'd3, PMP_ACC_EXEC, 2'd0, 1'b0, 6'd0, 1'b0, 17, 1'b1);
        wait_done();

        // TOR entry 1 taking its lower bound from entry 0's address: 0x1000..0x1FFF
        clear_cfg();
        pmpaddr[0] = 54'h400;
        pmpcfg[1]  = mk_cfg(1'b0, PMP_TOR, 1'b1, 1'b1, 1'b1);
        pmpaddr[1] = 54'h800;
        send(56'h1800, 2'd2, PMP_ACC_READ, 2'd0, 1'b1, 6'd1, 1'b1, 3, 1'b1);
        wait_done();

        // Partial overlap with NA4 entry 5 at 0x8000_0004
        clear_cfg();
        pmpcfg[5]  = mk_cfg(1'b0, PMP_NA4, 1'b0, 1'b1, 1'b1);
        pmpaddr[5] = 54'h2000_0001;
        send(56'h8000_0000, 2'd3, PMP_ACC_READ, 2'd0, 1'b1, 6'd5, 1'b0, 7, 1'b1);
        wait_done();

        // M-mode with everything off
        clear_cfg();
        send(56'h1234_5678, 2'd2, PMP_ACC_READ, 2'd3, 1'b0, 6'd0, 1'b1, 17, 1'b1);
        wait_done();

        // Entry 2 locked without R binds M-mode; unlocked it does not
        clear_cfg();
        pmpcfg[2]  = mk_cfg(1'b1, PMP_NAPOT, 1'b0, 1'b1, 1'b0);
        pmpaddr[2] = 54'h2000_01FF;
        send(56'h8000_0100, 2'd2, PMP_ACC_READ, 2'd3, 1'b1, 6'd2, 1'b0, 4, 1'b1);
        wait_done();
        pmpcfg[2]  = mk_cfg(1'b0, PMP_NAPOT, 1'b0, 1'b1, 1'b0);
        send(56'h8000_0100, 2'd2, PMP_ACC_READ, 2'd3, 1'b1, 6'd2, 1'b1, 4, 1'b1);
        wait_done();

        // Restart at ptr=7 adds 8 cycles; then hold the response for 10 cycles
        clear_cfg();
        resp_ready = 1'b0;
        send(56'h4000, 2'd0, PMP_ACC_WRITE, 2'd3, 1'b0, 6'd0, 1'b1, 17 + 8, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        pmp_cfg_upd = 1'b1;
        @(posedge clk);
        #1;
        pmp_cfg_upd = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("hold_resp_seen", 64'(resp_valid), 64'd1);
        repeat (10) @(negedge clk);
        resp_ready = 1'b1;
        wait_done();

        // Reset in the middle of a scan: no response, outputs reset at once
        clear_cfg();
        send(56'h8000_0000, 2'd3, PMP_ACC_READ, 2'd0, 1'b0, 6'd0, 1'b0, 17, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("scan_before_reset", 64'(dbg_state), 64'(CHK_SCAN));
        rstn = 1'b0;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'(CHK_IDLE));
        @(negedge clk);
        rstn = 1'b1;
        pmpcfg[3]  = mk_cfg(1'b0, PMP_NAPOT, 1'b0, 1'b0, 1'b1);
        pmpaddr[3] = 54'h2000_01FF;
        send(56'h8000_0100, 2'd3, PMP_ACC_READ, 2'd0, 1'b1, 6'd3, 1'b1, 5, 1'b1);
        wait_done();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
